// File: rtl/dwc_downconv_wr_cmd_sequencer_pkg.sv
// dwc_downconv_wr_cmd_sequencer_pkg: shared burst encodings, FSM states and sizing helpers.
package dwc_downconv_wr_cmd_sequencer_pkg;
  typedef enum logic [1:0] {BURST_FIXED = 2'd0, BURST_INCR = 2'd1, BURST_WRAP = 2'd2} burst_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ISSUE, S_NEXT} state_e;
  localparam int MAX_BEATS = 256;
  function automatic logic [2:0] ssize(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction
endpackage

// File: rtl/dwc_downconv_wr_cmd_sequencer_split_calc.sv
// dwc_wr_split_calc: per-command split parameters (ratio, offset, total beats, wrap mask) and next sub-burst address.
module dwc_wr_split_calc
  import dwc_downconv_wr_cmd_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int SLAVE_DATA_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [ADDR_WIDTH-1:0] cur_mask,
  input  logic [2:0]            cur_size,
  input  logic [1:0]            cur_burst,
  input  logic [8:0]            beats,
  output logic [2:0]            r,
  output logic [7:0]            off,
  output logic [15:0]           total,
  output logic [ADDR_WIDTH-1:0] start_addr,
  output logic [ADDR_WIDTH-1:0] wrap_mask,
  output logic [ADDR_WIDTH-1:0] next_addr
);
  localparam logic [2:0] SS = ssize(SLAVE_DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] SMASK = (ONE << SS) - ONE;
  logic [ADDR_WIDTH-1:0] lo;
  always_comb begin
    r = (size > SS) ? size - SS : 3'd0;
    lo = addr & ((ONE << size) - ONE);
    // WRAP bursts are size-aligned, so only INCR/FIXED carry a leading partial beat
    off = (r != 3'd0 && burst != BURST_WRAP) ? 8'(lo >> SS) : 8'd0;
    total = ((16'(len) + 16'd1) << r) - 16'(off);
    start_addr = (r == 3'd0) ? addr : addr & ~SMASK;
    wrap_mask = ((ADDR_WIDTH'(len) + ONE) << size) - ONE;
    next_addr = (cur_burst == BURST_WRAP) ? (cur_addr & ~cur_mask) | ((cur_addr + (ONE << cur_size)) & cur_mask) :
                (cur_burst == BURST_FIXED) ? cur_addr : cur_addr + (ADDR_WIDTH'(beats) << SS);
  end
endmodule

// File: rtl/dwc_downconv_wr_cmd_sequencer.sv
// dwc_downconv_wr_cmd_sequencer: splits held master write commands into slave-width AW bursts plus W beat counts.
module dwc_downconv_wr_cmd_sequencer
  import dwc_downconv_wr_cmd_sequencer_pkg::*;
#(
  parameter int ID_WIDTH = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int SLAVE_DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  sysReset,
  input  logic                  hold_reg_empty,
  output logic                  hold_get_next_data,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  output logic                  SLAVE_AWVALID,
  input  logic                  SLAVE_AWREADY,
  output logic [ADDR_WIDTH-1:0] SLAVE_AWADDR,
  output logic [7:0]            SLAVE_AWLEN,
  output logic [2:0]            SLAVE_AWSIZE,
  output logic [1:0]            SLAVE_AWBURST,
  output logic [ID_WIDTH-1:0]   SLAVE_AWID,
  output logic                  wr_beats_valid,
  input  logic                  wr_beats_ready,
  output logic [8:0]            wr_beats_cnt,
  output logic                  wr_beats_last,
  output logic                  busy
);
  localparam logic [2:0] SS = ssize(SLAVE_DATA_WIDTH);
  state_e state, state_nxt;
  logic [ADDR_WIDTH-1:0] q_addr, q_mask, start_addr, wrap_mask, next_addr;
  logic [2:0] q_size, q_r, r;
  logic [1:0] q_burst;
  logic [ID_WIDTH-1:0] q_id;
  logic [7:0] q_off, off;
  logic [15:0] rem, total;
  logic [8:0] step_beats, cap, beats;
  logic first, aw_done, wb_done, aw_fin, wb_fin;

  dwc_wr_split_calc #(.ADDR_WIDTH(ADDR_WIDTH), .SLAVE_DATA_WIDTH(SLAVE_DATA_WIDTH)) u_calc (
    .addr(cmd_addr), .len(cmd_len), .size(cmd_size), .burst(cmd_burst),
    .cur_addr(q_addr), .cur_mask(q_mask), .cur_size(q_size), .cur_burst(q_burst), .beats(step_beats),
    .r(r), .off(off), .total(total), .start_addr(start_addr), .wrap_mask(wrap_mask), .next_addr(next_addr)
  );

  // INCR splits at the 256-beat limit; FIXED/WRAP split per master beat
  assign cap = (q_r == 3'd0 || q_burst == BURST_INCR) ? 9'(MAX_BEATS) : (9'd1 << q_r) - {1'b0, first ? q_off : 8'd0};
  assign beats = (rem < {7'd0, cap}) ? rem[8:0] : cap;
  assign SLAVE_AWVALID = (state == S_ISSUE) && !aw_done;
  assign wr_beats_valid = (state == S_ISSUE) && !wb_done;
  assign aw_fin = aw_done || (SLAVE_AWVALID && SLAVE_AWREADY);
  assign wb_fin = wb_done || (wr_beats_valid && wr_beats_ready);
  assign SLAVE_AWADDR = q_addr;
  assign SLAVE_AWLEN = (beats == 9'd0) ? 8'd0 : 8'(beats - 9'd1);
  assign SLAVE_AWSIZE = (q_r == 3'd0) ? q_size : SS;
  assign SLAVE_AWBURST = (q_r == 3'd0) ? q_burst : BURST_INCR;
  assign SLAVE_AWID = q_id;
  assign wr_beats_cnt = beats;
  assign wr_beats_last = (beats != 9'd0) && (rem == {7'd0, beats});
  assign busy = state != S_IDLE;
  assign hold_get_next_data = (state == S_NEXT) && (rem == 16'd0);

  always_ff @(posedge ACLK or negedge sysReset)
    if (!sysReset) state <= S_IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = hold_reg_empty ? S_IDLE : S_LOAD;
      S_LOAD:  state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = (aw_fin && wb_fin) ? S_NEXT : S_ISSUE;
      default: state_nxt = (rem == 16'd0) ? S_IDLE : S_ISSUE;
    endcase
  end

  always_ff @(posedge ACLK or negedge sysReset)
    if (!sysReset) begin
      q_addr <= '0;
      q_mask <= '0;
      q_size <= '0;
      q_burst <= '0;
      q_id <= '0;
      q_r <= '0;
      q_off <= '0;
      rem <= '0;
      step_beats <= '0;
      first <= 1'b0;
      aw_done <= 1'b0;
      wb_done <= 1'b0;
    end else if (state == S_LOAD) begin
      q_addr <= start_addr;
      q_mask <= wrap_mask;
      q_size <= cmd_size;
      q_burst <= cmd_burst;
      q_id <= cmd_id;
      q_r <= r;
      q_off <= off;
      rem <= total;
      first <= 1'b1;
      aw_done <= 1'b0;
      wb_done <= 1'b0;
    end else if (state == S_ISSUE) begin
      if (aw_fin && wb_fin) begin
        aw_done <= 1'b0;
        wb_done <= 1'b0;
        rem <= rem - {7'd0, beats};
        step_beats <= beats;
        first <= 1'b0;
      end else begin
        aw_done <= aw_fin;
        wb_done <= wb_fin;
      end
    end else if (state == S_NEXT && rem != 16'd0) begin
      q_addr <= next_addr;
    end
endmodule
